mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, its fetch/data requesters and the shared memory port.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stall;
  logic        err;
  logic [1:0]  dbg_state;

  // Handshake: a requester raises *_req with stable fields and holds them until its one-cycle
  // *_ready pulse; the arbiter holds bus_req and the bus fields stable until the one-cycle bus_ack.
  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, bus_rdata, bus_ack,
    output i_data, i_ready, d_rdata, d_ready, bus_req, bus_we, bus_addr, bus_wdata,
           stall, err, dbg_state
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, bus_rdata, bus_ack,
    input  i_data, i_ready, d_rdata, d_ready, bus_req, bus_we, bus_addr, bus_wdata,
           stall, err, dbg_state
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port with data priority and a starvation cap.
// Optional bus timeout is enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master arb
);
  typedef enum logic [1:0] {IDLE = 2'd0, I_BUS = 2'd1, D_BUS = 2'd2, DONE = 2'd3} state_e;

  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  state_e        state_q;
  logic          bus_req_q;
  logic          bus_we_q;
  logic [31:0]   bus_addr_q;
  logic [31:0]   bus_wdata_q;
  logic [31:0]   i_data_q;
  logic [31:0]   d_rdata_q;
  logic          i_ready_q;
  logic          d_ready_q;
  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic          pick_data;
  logic          pick_fetch;
  logic          bus_done;
  logic [31:0]   done_val;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q;
  logic          err_q;
`endif

  // Data wins unless the fetch side has already watched MAX_D_STREAK data grants go by.
  always_comb begin
    pick_data  = arb.d_req && (!arb.i_req || (streak_q != STREAK_MAX));
    pick_fetch = arb.i_req && !pick_data;
    if (!arb.i_req) begin
      streak_d = '0;
    end else if (streak_q == STREAK_MAX) begin
      streak_d = streak_q;
    end else begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_comb begin
    bus_done = 1'b0;
    done_val = arb.bus_rdata;
    if ((state_q == I_BUS) || (state_q == D_BUS)) begin
      if (arb.bus_ack) begin
        bus_done = 1'b1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (tmo_q == TMO_LAST) begin
        bus_done = 1'b1;
        done_val = 32'hDEADBEEF;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      i_data_q    <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      streak_q    <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick_data) begin
            state_q     <= D_BUS;
            bus_req_q   <= 1'b1;
            bus_we_q    <= arb.d_we;
            bus_addr_q  <= arb.d_addr;
            bus_wdata_q <= arb.d_wdata;
            streak_q    <= streak_d;
          end else if (pick_fetch) begin
            state_q     <= I_BUS;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= arb.i_addr;
            bus_wdata_q <= '0;
            streak_q    <= '0;
          end
`ifdef ARB_TIMEOUT_EN
          tmo_q <= '0;
`endif
        end
        I_BUS, D_BUS: begin
          if (bus_done) begin
            bus_req_q <= 1'b0;
            state_q   <= DONE;
`ifdef ARB_TIMEOUT_EN
            err_q     <= !arb.bus_ack;
`endif
            if (state_q == I_BUS) begin
              i_data_q  <= done_val;
              i_ready_q <= 1'b1;
            end else begin
              // Writes complete without touching the read register.
              if (!bus_we_q) d_rdata_q <= done_val;
              d_ready_q <= 1'b1;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb.bus_req   = bus_req_q;
  assign arb.bus_we    = bus_we_q;
  assign arb.bus_addr  = bus_addr_q;
  assign arb.bus_wdata = bus_wdata_q;
  assign arb.i_data    = i_data_q;
  assign arb.i_ready   = i_ready_q;
  assign arb.d_rdata   = d_rdata_q;
  assign arb.d_ready   = d_ready_q;
  assign arb.stall     = (arb.i_req & ~i_ready_q) | (arb.d_req & ~d_ready_q);
  assign arb.dbg_state = state_q;
`ifdef ARB_TIMEOUT_EN
  assign arb.err = err_q;
`else
  // Without the timeout there is no error source; the comparison is never true.
  assign arb.err = (TIMEOUT_CYCLES < 0);
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model, directed scenarios, random traffic.
module tb_mem_arbiter;
  localparam int MAX_D = 4;
  localparam int TMO   = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if vif();
  mem_arbiter #(.MAX_D_STREAK(MAX_D), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .arb(vif));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- reference model: one outstanding transaction record ----------------
  bit          m_busy = 1'b0, m_done = 1'b0, m_fresh = 1'b1, m_owner_d = 1'b0, m_we = 1'b0;
  bit          m_i_ready = 1'b0, m_d_ready = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_i_data = '0, m_d_rdata = '0;
  int          m_streak = 0, m_wait = 0;
  bit          chk_en = 1'b0;

  task automatic m_finish(input logic [31:0] v, input bit timed_out);
    m_busy = 1'b0;
    m_done = 1'b1;
    m_err  = timed_out;
    if (!m_owner_d) begin
      m_i_data  = v;
      m_i_ready = 1'b1;
    end else begin
      if (!m_we) m_d_rdata = v;
      m_d_ready = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    m_i_ready = 1'b0;
    m_d_ready = 1'b0;
    m_err     = 1'b0;
    if (!rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_fresh = 1'b1; m_owner_d = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_i_data = '0; m_d_rdata = '0; m_streak = 0; m_wait = 0;
    end else if (m_busy) begin
      if (vif.bus_ack) m_finish(vif.bus_rdata, 1'b0);
      else begin
        m_wait++;
        if (TMO_ON && m_wait == TMO) m_finish(32'hDEADBEEF, 1'b1);
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (vif.d_req && (!vif.i_req || m_streak < MAX_D)) begin
      m_streak  = vif.i_req ? ((m_streak < MAX_D) ? m_streak + 1 : MAX_D) : 0;
      m_busy    = 1'b1; m_owner_d = 1'b1; m_fresh = 1'b0; m_wait = 0;
      m_we      = vif.d_we; m_addr = vif.d_addr; m_wdata = vif.d_wdata;
    end else if (vif.i_req) begin
      m_streak  = 0;
      m_busy    = 1'b1; m_owner_d = 1'b0; m_fresh = 1'b0; m_wait = 0;
      m_we      = 1'b0; m_addr = vif.i_addr;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check1("bus_req", vif.bus_req, m_busy);
      if (m_busy || m_fresh) begin
        check1("bus_we", vif.bus_we, m_we);
        check32("bus_addr", vif.bus_addr, m_addr);
        if (m_owner_d || m_fresh) check32("bus_wdata", vif.bus_wdata, m_wdata);
      end
      check1("i_ready", vif.i_ready, m_i_ready);
      check1("d_ready", vif.d_ready, m_d_ready);
      check1("err", vif.err, m_err);
      check32("i_data", vif.i_data, m_i_data);
      check32("d_rdata", vif.d_rdata, m_d_rdata);
      check1("stall", vif.stall, (vif.i_req & ~m_i_ready) | (vif.d_req & ~m_d_ready));
    end
  end

  // ---------------- memory slave ----------------
  bit          no_ack = 1'b0, spurious_en = 1'b0, rdata_fixed = 1'b1;
  int          fix_delay = 0;
  logic [31:0] rdata_val = '0;

  initial begin
    int wait_cnt;
    int cur_delay;
    vif.bus_ack   = 1'b0;
    vif.bus_rdata = '0;
    wait_cnt      = 0;
    cur_delay     = 0;
    forever begin
      tick();
      if (vif.bus_req && !no_ack) begin
        if (wait_cnt == 0) cur_delay = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 3));
        if (wait_cnt >= cur_delay) begin
          vif.bus_ack   = 1'b1;
          vif.bus_rdata = rdata_fixed ? rdata_val : $urandom;
          wait_cnt      = 0;
        end else begin
          vif.bus_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        vif.bus_ack   = spurious_en && ($urandom_range(0, 7) == 0);
        vif.bus_rdata = $urandom;
        wait_cnt      = 0;
      end
    end
  end

  // ---------------- directed and random stimulus ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  initial begin
    int cnt;
    bit got;
    int dcount;
    logic [7:0] g;

    vif.i_req = 1'b0; vif.i_addr = '0; vif.d_req = 1'b0; vif.d_we = 1'b0;
    vif.d_addr = '0; vif.d_wdata = '0;
    repeat (3) tick();
    chk_en = 1'b1;
    check1("rst_bus_req", vif.bus_req, 1'b0);
    check32("rst_bus_addr", vif.bus_addr, 32'h0);
    check32("rst_i_data", vif.i_data, 32'h0);
    check32("rst_dbg_state", {30'd0, vif.dbg_state}, 32'h0);
    rst = 1'b1;
    tick();

    // Fetch at minimum latency
    rdata_val = 32'h2402000A;
    vif.i_req = 1'b1; vif.i_addr = 32'h100;
    tick();
    check1("fetch_bus_req_c1", vif.bus_req, 1'b1);
    check32("fetch_bus_addr_c1", vif.bus_addr, 32'h100);
    check1("fetch_bus_we_c1", vif.bus_we, 1'b0);
    tick();
    check1("fetch_i_ready_c2", vif.i_ready, 1'b1);
    check32("fetch_i_data_c2", vif.i_data, 32'h2402000A);
    check1("fetch_bus_req_c2", vif.bus_req, 1'b0);
    vif.i_req = 1'b0;
    tick();
    check1("fetch_i_ready_c3", vif.i_ready, 1'b0);
    check1("fetch_stall_c3", vif.stall, 1'b0);

    // Contention: data first, then fetch
    rdata_val = 32'h11112222;
    vif.i_req = 1'b1; vif.i_addr = 32'h200;
    vif.d_req = 1'b1; vif.d_we = 1'b0; vif.d_addr = 32'h10000004;
    tick();
    check32("cont_first_addr", vif.bus_addr, 32'h10000004);
    check1("cont_stall", vif.stall, 1'b1);
    tick();
    check1("cont_d_ready", vif.d_ready, 1'b1);
    check1("cont_i_ready_low", vif.i_ready, 1'b0);
    check32("cont_d_rdata", vif.d_rdata, 32'h11112222);
    vif.d_req = 1'b0;
    rdata_val = 32'h33334444;
    tick();
    tick();
    check32("cont_second_addr", vif.bus_addr, 32'h200);
    tick();
    check1("cont_i_ready", vif.i_ready, 1'b1);
    check32("cont_i_data", vif.i_data, 32'h33334444);
    vif.i_req = 1'b0;
    tick();

    // Write held for three bus cycles
    fix_delay = 2;
    vif.d_req = 1'b1; vif.d_we = 1'b1; vif.d_addr = 32'h10000000; vif.d_wdata = 32'hCAFEF00D;
    cnt = 0; got = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (vif.bus_req) begin
        cnt++;
        check1("wr_bus_we", vif.bus_we, 1'b1);
        check32("wr_bus_addr", vif.bus_addr, 32'h10000000);
        check32("wr_bus_wdata", vif.bus_wdata, 32'hCAFEF00D);
      end
      if (vif.d_ready) begin
        got = 1'b1;
        check32("wr_d_rdata_kept", vif.d_rdata, 32'h11112222);
        vif.d_req = 1'b0;
        break;
      end
    end
    check1("wr_done", got, 1'b1);
    check32("wr_bus_cycles", cnt, 32'd3);
    tick();
    check1("wr_d_ready_one_cycle", vif.d_ready, 1'b0);
    fix_delay = 0;
    vif.d_we = 1'b0;

    // Starvation cap: four data grants, one fetch, then the fifth data grant
    for (int k = 0; k < 6; k++) exp_q.push_back((k == 4) ? 8'h49 : 8'h44);
    vif.i_req = 1'b1; vif.i_addr = 32'h300;
    vif.d_req = 1'b1; vif.d_addr = 32'h10000100;
    dcount = 0;
    for (int c = 0; c < 100 && (dcount < 5 || vif.i_req); c++) begin
      tick();
      if (vif.d_ready) begin
        got_q.push_back(8'h44);
        dcount++;
        if (dcount == 5) vif.d_req = 1'b0;
        else vif.d_addr = vif.d_addr + 32'd4;
      end
      if (vif.i_ready) begin
        got_q.push_back(8'h49);
        vif.i_req = 1'b0;
      end
    end
    vif.i_req = 1'b0; vif.d_req = 1'b0;
    check32("starve_count", got_q.size(), 32'd6);
    while (exp_q.size() > 0) begin
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'h00;
      check32("starve_order", {24'd0, g}, {24'd0, exp_q.pop_front()});
    end
    tick();

    // Reset in the middle of a data bus wait
    no_ack = 1'b1;
    vif.d_req = 1'b1; vif.d_addr = 32'h10000008;
    tick();
    tick();
    check1("rst_mid_bus_req_before", vif.bus_req, 1'b1);
    rst = 1'b0;
    tick();
    check1("rst_mid_bus_req", vif.bus_req, 1'b0);
    check1("rst_mid_d_ready", vif.d_ready, 1'b0);
    check32("rst_mid_i_data", vif.i_data, 32'h0);
    check32("rst_mid_d_rdata", vif.d_rdata, 32'h0);
    check32("rst_mid_bus_addr", vif.bus_addr, 32'h0);
    check1("rst_mid_err", vif.err, 1'b0);
    rst = 1'b1; vif.d_req = 1'b0; no_ack = 1'b0;
    tick();
    check1("rst_after_d_ready", vif.d_ready, 1'b0);
    tick();

`ifdef ARB_TIMEOUT_EN
    // Read that is never acknowledged
    no_ack = 1'b1;
    vif.d_req = 1'b1; vif.d_we = 1'b0; vif.d_addr = 32'h10000010;
    cnt = 0; got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (vif.bus_req) cnt++;
      if (vif.d_ready) begin
        got = 1'b1;
        check1("tmo_err", vif.err, 1'b1);
        check32("tmo_d_rdata", vif.d_rdata, 32'hDEADBEEF);
        vif.d_req = 1'b0;
        break;
      end
    end
    check1("tmo_done", got, 1'b1);
    check32("tmo_bus_cycles", cnt, 32'd8);
    no_ack = 1'b0;
    tick();
    tick();
`endif

    // Random traffic with spurious acks, early request drops and occasional resets
    spurious_en = 1'b1; rdata_fixed = 1'b0; fix_delay = -1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if (!vif.i_req) begin
        if ($urandom_range(0, 2) == 0) begin
          vif.i_req = 1'b1; vif.i_addr = $urandom;
        end
      end else if (m_i_ready || $urandom_range(0, 49) == 0) begin
        if ($urandom_range(0, 1) == 0) vif.i_req = 1'b0;
        else vif.i_addr = $urandom;
      end
      if (!vif.d_req) begin
        if ($urandom_range(0, 1) == 0) begin
          vif.d_req = 1'b1; vif.d_we = 1'($urandom_range(0, 1));
          vif.d_addr = $urandom; vif.d_wdata = $urandom;
        end
      end else if (m_d_ready || $urandom_range(0, 49) == 0) begin
        if ($urandom_range(0, 2) == 0) vif.d_req = 1'b0;
        else begin
          vif.d_we = 1'($urandom_range(0, 1)); vif.d_addr = $urandom; vif.d_wdata = $urandom;
        end
      end
    end
    rst = 1'b1; vif.i_req = 1'b0; vif.d_req = 1'b0; spurious_en = 1'b0;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
